multicycle_core: RTL and testbench

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/multicycle_core.sv | 166 ++++++++++++++++
 tb/tb_multicycle_core.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core.sv
// multicycle_core: three-state-per-instruction RV subset core.
// Fetch request, fetch wait, single-cycle execute; halts on EBREAK/illegal.
module multicycle_core #(
  parameter int XLEN = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [XLEN-1:0] current_pc,
  output logic            retire,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] halt_a0
);

  localparam logic [1:0] FETCH_REQ  = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] EXEC       = 2'd2;
  localparam logic [1:0] HALT       = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic            run_q, run_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;

  assign op  = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  logic [XLEN-1:0] imm_i, imm_u, imm_j;
  assign imm_i = XLEN'($signed(ir_q[31:20]));
  assign imm_u = XLEN'($signed({ir_q[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({ir_q[31], ir_q[19:12],
                                ir_q[20], ir_q[30:21], 1'b0}));

  logic [XLEN-1:0] rs1_v, rs2_v, pc_plus4, jalr_t;
  assign rs1_v    = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign pc_plus4 = pc_q + XLEN'(4);
  assign jalr_t   = rs1_v + imm_i;

  logic is_addi, is_add, is_sub, is_lui;
  logic is_auipc, is_jal, is_jalr, is_brk;
  assign is_addi  = (op == 7'h13) && (f3 == 3'd0);
  assign is_add   = (op == 7'h33) && (f3 == 3'd0)
                    && (f7 == 7'h00);
  assign is_sub   = (op == 7'h33) && (f3 == 3'd0)
                    && (f7 == 7'h20);
  assign is_lui   = (op == 7'h37);
  assign is_auipc = (op == 7'h17);
  assign is_jal   = (op == 7'h6f);
  assign is_jalr  = (op == 7'h67) && (f3 == 3'd0);
  assign is_brk   = (ir_q == 32'h0010_0073);

  logic            dec_wr, dec_ill, dec_brk;
  logic [XLEN-1:0] wb, pc_next;

  // Decode and execute the held instruction.
  always_comb begin
    wb      = '0;
    pc_next = pc_plus4;
    dec_wr  = 1'b0;
    dec_ill = 1'b0;
    dec_brk = 1'b0;
    unique case (1'b1)
      is_addi:  begin wb = rs1_v + imm_i; dec_wr = 1'b1; end
      is_add:   begin wb = rs1_v + rs2_v; dec_wr = 1'b1; end
      is_sub:   begin wb = rs1_v - rs2_v; dec_wr = 1'b1; end
      is_lui:   begin wb = imm_u; dec_wr = 1'b1; end
      is_auipc: begin wb = pc_q + imm_u; dec_wr = 1'b1; end
      is_jal: begin
        wb      = pc_plus4;
        pc_next = pc_q + imm_j;
        dec_wr  = 1'b1;
      end
      is_jalr: begin
        wb      = pc_plus4;
        pc_next = {jalr_t[XLEN-1:1], 1'b0};
        dec_wr  = 1'b1;
      end
      is_brk:   dec_brk = 1'b1;
      default:  dec_ill = 1'b1;
    endcase
  end

  logic rf_we;

  // Sequencer: request, wait for data, execute once, repeat.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ill_d   = ill_q;
    run_d   = 1'b1;
    rf_we   = 1'b0;
    case (state_q)
      FETCH_REQ:
        if (run_q && imem_req_ready) state_d = FETCH_WAIT;
      FETCH_WAIT:
        if (imem_rsp_valid) begin
          ir_d    = imem_rsp_data;
          state_d = EXEC;
        end
      EXEC:
        if (dec_ill) begin
          ill_d   = 1'b1;
          state_d = HALT;
        end else begin
          pc_d    = pc_next;
          rf_we   = dec_wr && (rd != 5'd0);
          state_d = dec_brk ? HALT : FETCH_REQ;
        end
      default: state_d = HALT;
    endcase
  end

  // Control state; run_q holds off requests until after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      run_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      run_q   <= run_d;
      ill_q   <= ill_d;
    end
  end

  // Register file, cleared by reset, written only in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rd] <= wb;
    end
  end

  assign imem_req_valid = (state_q == FETCH_REQ) && run_q;
  assign imem_addr      = pc_q;
  assign current_pc     = pc_q;
  assign retire         = (state_q == EXEC) && !dec_ill;
  assign halted         = (state_q == HALT);
  assign illegal        = ill_q;
  assign halt_a0        = halted ? rf_q[10] : '0;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed program table plus corner sequences.
// Runs a 64-bit and a 32-bit core in lockstep on one memory model.
module tb_multicycle_core;

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [31:0] BRK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  logic        req_v, ret, hlt, ill;
  logic [63:0] addr, pc, a0;
  logic        req_v32, ret32, hlt32, ill32;
  logic [31:0] addr32, pc32, a032;

  multicycle_core #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_v),
    .imem_req_ready(imem_req_ready),
    .imem_addr(addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .current_pc(pc), .retire(ret),
    .halted(hlt), .illegal(ill),
    .halt_a0(a0)
  );

  multicycle_core #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_v32),
    .imem_req_ready(imem_req_ready),
    .imem_addr(addr32),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .current_pc(pc32), .retire(ret32),
    .halted(hlt32), .illegal(ill32),
    .halt_a0(a032)
  );

  logic [31:0] prog [16];
  logic [63:0] pend;
  logic [63:0] off;
  logic        stale_en = 1'b0;
  logic [31:0] stale_word = 32'h0070_0513;

  always @(posedge clk)
    if (req_v && imem_req_ready) pend <= addr;

  always_comb begin
    off = (pend - RPC) >> 2;
    if (stale_en) imem_rsp_data = stale_word;
    else if (off < 64'd16) imem_rsp_data = prog[off[3:0]];
    else imem_rsp_data = 32'h0;
  end

  typedef struct {
    logic [5:0][31:0] w;
    logic [63:0]      a0;
    logic             il;
    int               rets;
  } vec_t;

  vec_t vt [$];
  int   ret_cyc [$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] w0, w1, w2,
                     input logic [31:0] w3, w4, w5,
                     input logic [63:0] ea0,
                     input logic eil, input int er);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    v.a0 = ea0; v.il = eil; v.rets = er;
    vt.push_back(v);
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 16; k++)
      prog[k] = (k < 6) ? v.w[k] : 32'h0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    stale_en = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_rst_req"}, {63'd0, req_v}, 64'd0);
    chk({tag, "_rst_pc"}, pc, RPC);
    chk({tag, "_rst_flags"},
        {61'd0, hlt, ill, ret}, 64'd0);
    chk({tag, "_rst_a0"}, a0, 64'd0);
    rst = 1'b0;
  endtask

  task automatic run(input int c0, output int rets,
                     output int rets32, output int hs);
    bit done;
    done = 1'b0;
    rets = 0; rets32 = 0; hs = 0;
    ret_cyc.delete();
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (ret) begin rets++; ret_cyc.push_back(c0 + i); end
      if (ret32) rets32++;
      if (req_v && imem_req_ready) hs++;
      if (hlt) done = 1'b1;
    end
    chk("halt_timeout", {63'd0, hlt}, 64'd1);
  endtask

  initial begin
    int r, r32, hs, n;
    bit quiet;
    vec_t v;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;

    add(32'h0050_0513, BRK, 0, 0, 0, 0,
        64'd5, 1'b0, 2);
    add(32'hFFF0_0513, BRK, 0, 0, 0, 0,
        64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2);
    add(32'h0070_0093, 32'h0030_0113,
        32'h4020_8533, BRK, 0, 0,
        64'd4, 1'b0, 4);
    add(32'h0070_0093, 32'h0030_0113,
        32'h0020_8533, BRK, 0, 0,
        64'd10, 1'b0, 4);
    add(32'h0050_0013, 32'h0000_0533, BRK,
        0, 0, 0, 64'd0, 1'b0, 3);
    add(32'h8000_00B7, 32'h0000_8513, BRK,
        0, 0, 0, 64'hFFFF_FFFF_8000_0000, 1'b0, 3);
    add(32'h0, 0, 0, 0, 0, 0, 64'd0, 1'b1, 0);
    add(32'h0080_056F, 32'h0, BRK, 0, 0, 0,
        64'h8000_0004, 1'b0, 2);
    add(32'h0050_0513, 32'h0015_1513, 0, 0, 0, 0,
        64'd5, 1'b1, 1);
    add(32'h0010_0093, 32'h4010_0533, BRK,
        0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3);
    add(32'h0000_1517, BRK, 0, 0, 0, 0,
        64'h8000_1000, 1'b0, 2);
    add(32'h0000_0097, 32'h0100_8093,
        32'h0030_80E7, 32'h0, 32'h0000_8513, BRK,
        64'h8000_000C, 1'b0, 5);

    for (int i = 0; i < vt.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      load(vt[i]);
      do_reset(t);
      run(1, r, r32, hs);
      chk({t, "_ill"}, {63'd0, ill}, {63'd0, vt[i].il});
      chk({t, "_a0"}, a0, vt[i].a0);
      chk({t, "_rets"}, 64'(r), 64'(vt[i].rets));
      chk({t, "_a0_32"}, {32'd0, a032},
          {32'd0, vt[i].a0[31:0]});
      chk({t, "_ill32"}, {62'd0, hlt32, ill32},
          {62'd0, 1'b1, vt[i].il});
      chk({t, "_rets32"}, 64'(r32), 64'(vt[i].rets));
    end

    // ADDI x10,x0,5; EBREAK with zero-latency memory
    load(vt[0]);
    do_reset("lat");
    run(1, r, r32, hs);
    chk("lat_nret", 64'(ret_cyc.size()), 64'd2);
    if (ret_cyc.size() == 2) begin
      chk("lat_ret0", 64'(ret_cyc[0]), 64'd3);
      chk("lat_ret1", 64'(ret_cyc[1]), 64'd6);
    end
    chk("lat_a0", a0, 64'd5);

    // request held off by ready for four cycles
    v = vt[0];
    v.w[0] = BRK;
    load(v);
    do_reset("rdy");
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rdy_hold%0d", k),
          {req_v, addr}, {1'b1, RPC});
      chk($sformatf("rdy_hold32_%0d", k),
          {32'd0, addr32}, {32'd0, RPC[31:0]});
    end
    imem_req_ready = 1'b1;
    n = (req_v && imem_req_ready) ? 1 : 0;
    run(5, r, r32, hs);
    chk("rdy_handshakes", 64'(n + hs), 64'd1);
    chk("rdy_rets", 64'(r), 64'd1);

    // JALR x1,x1,3 lands on a half-word aligned PC
    load(vt[11]);
    do_reset("jalr");
    n = 0;
    for (int k = 0; k < 60 && n < 3; k++) begin
      @(negedge clk);
      if (ret) n++;
    end
    @(negedge clk);
    chk("jalr_pc", pc, 64'h8000_0012);
    chk("jalr_addr", {63'd0, req_v}, 64'd1);
    run(2, r, r32, hs);
    chk("jalr_link", a0, 64'h8000_000C);

    // all-zero word is illegal: halt without retire
    load(vt[6]);
    do_reset("zero");
    run(1, r, r32, hs);
    chk("zero_flags", {62'd0, hlt, ill}, 64'd3);
    chk("zero_rets", 64'(r), 64'd0);
    chk("zero_pc", pc, RPC);
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (req_v || req_v32 || ret || !hlt) quiet = 1'b0;
    end
    chk("zero_quiet", {63'd0, quiet}, 64'd1);
    chk("zero_pc32", {32'd0, pc32}, {32'd0, RPC[31:0]});

    // reset in FETCH_WAIT, stale response afterwards
    load(v);
    do_reset("abort");
    imem_rsp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_wait", {63'd0, req_v}, 64'd0);
    rst = 1'b1;
    #1;
    chk("abort_rst_pc", pc, RPC);
    chk("abort_rst_req", {63'd0, req_v}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    imem_rsp_valid = 1'b1;
    stale_en = 1'b1;
    @(negedge clk);
    stale_en = 1'b0;
    chk("abort_refetch", {req_v, addr}, {1'b1, RPC});
    run(2, r, r32, hs);
    chk("abort_rets", 64'(r), 64'd1);
    chk("abort_a0", a0, 64'd0);
    chk("abort_ill", {63'd0, ill}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
